wb_write_queue: RTL and testbench

// - Write-back collector directly upstream of multiport_ram. Accepts write requests from P_NUM_SRC

---
 rtl/wb_write_queue_pkg.sv | 18 +
 rtl/wb_write_queue_rr_grant2.sv | 48 ++++
 rtl/wb_write_queue.sv | 164 ++++++++++++++++
 tb/tb_wb_write_queue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_queue_pkg.sv
// Shared types and helpers for the write-back queue.
// Entry layout matches the default RAM geometry (2048 x 32).
package vp_wb_pkg;

  localparam int unsigned VP_DEF_INDEX_WIDTH = 11;
  localparam int unsigned VP_DEF_MEM_WIDTH   = 32;

  typedef struct packed {
    logic [VP_DEF_INDEX_WIDTH-1:0] addr;
    logic [VP_DEF_MEM_WIDTH-1:0]   data;
  } wb_entry_t;

  // Round-robin successor of a granted source index.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_src);
    return (idx + 1 >= num_src) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_write_queue_rr_grant2.sv
// Round-robin arbiter granting up to two requesters per cycle, limited by free slots.
// grant_a_o marks the first (older) grant, grant_b_o the second.
module wb_rr_grant2
  import vp_wb_pkg::*;
#(
  parameter  int unsigned P_NUM_SRC    = 4,
  parameter  int unsigned P_FREE_WIDTH = 4,
  localparam int unsigned LP_RR_WIDTH  = $clog2(P_NUM_SRC)
) (
  input  logic [P_NUM_SRC-1:0]    src_valid_i,
  input  logic [LP_RR_WIDTH-1:0]  rr_i,
  input  logic [P_FREE_WIDTH-1:0] free_i,
  output logic [P_NUM_SRC-1:0]    grant_a_o,
  output logic [P_NUM_SRC-1:0]    grant_b_o,
  output logic [1:0]              grant_cnt_o,
  output logic [LP_RR_WIDTH-1:0]  rr_next_o
);

  logic [1:0]             max_grants;
  logic [LP_RR_WIDTH:0]   scan;
  logic [LP_RR_WIDTH-1:0] idx;

  always_comb begin
    if (free_i >= P_FREE_WIDTH'(2)) max_grants = 2'd2;
    else                             max_grants = free_i[1:0];
  end

  always_comb begin
    grant_a_o   = '0;
    grant_b_o   = '0;
    grant_cnt_o = '0;
    rr_next_o   = rr_i;
    scan        = '0;
    idx         = '0;
    for (int k = 0; k < P_NUM_SRC; k++) begin
      scan = {1'b0, rr_i} + (LP_RR_WIDTH+1)'(k);
      if (scan >= (LP_RR_WIDTH+1)'(P_NUM_SRC)) scan = scan - (LP_RR_WIDTH+1)'(P_NUM_SRC);
      idx = scan[LP_RR_WIDTH-1:0];
      if (src_valid_i[idx] && (grant_cnt_o < max_grants)) begin
        if (grant_cnt_o == 2'd0) grant_a_o[idx] = 1'b1;
        else                     grant_b_o[idx] = 1'b1;
        grant_cnt_o = grant_cnt_o + 2'd1;
        rr_next_o   = LP_RR_WIDTH'(rr_next(32'(idx), P_NUM_SRC));
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// In-order write collector feeding both RAM write ports, up to two writes per cycle.
// Same-address head pairs are split across cycles so port A/B never collide.
module wb_write_queue
  import vp_wb_pkg::*;
#(
  parameter  int unsigned P_MEM_DEPTH    = 2048,
  parameter  int unsigned P_MEM_WIDTH    = 32,
  parameter  int unsigned P_NUM_SRC      = 4,
  parameter  int unsigned P_FIFO_DEPTH   = 8,
  localparam int unsigned LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH),
  localparam int unsigned LP_PTR_WIDTH   = $clog2(P_FIFO_DEPTH),
  localparam int unsigned LP_CNT_WIDTH   = LP_PTR_WIDTH + 1,
  localparam int unsigned LP_RR_WIDTH    = $clog2(P_NUM_SRC)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [P_NUM_SRC-1:0]                src_valid_i,
  input  logic [P_NUM_SRC*LP_INDEX_WIDTH-1:0] src_addr_i,
  input  logic [P_NUM_SRC*P_MEM_WIDTH-1:0]    src_data_i,
  output logic [P_NUM_SRC-1:0]                src_ready_o,
  output logic [LP_INDEX_WIDTH-1:0]           wra_addr_o,
  output logic [P_MEM_WIDTH-1:0]              wra_data_o,
  output logic                                wra_valid_o,
  output logic [LP_INDEX_WIDTH-1:0]           wrb_addr_o,
  output logic [P_MEM_WIDTH-1:0]              wrb_data_o,
  output logic                                wrb_valid_o,
  input  logic [LP_INDEX_WIDTH-1:0]           lookup_addr_i,
  output logic                                lookup_hit_o,
  output logic                                busy_o
);

  typedef struct packed {
    logic [LP_INDEX_WIDTH-1:0] addr;
    logic [P_MEM_WIDTH-1:0]    data;
  } entry_t;

  entry_t                    mem_q [P_FIFO_DEPTH];
  entry_t                    mem_d [P_FIFO_DEPTH];
  logic [LP_PTR_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [LP_CNT_WIDTH-1:0]   count_q, count_d, free;
  logic [LP_RR_WIDTH-1:0]    rr_q, rr_d, rr_nxt;
  logic [P_NUM_SRC-1:0]      grant_a, grant_b;
  logic [1:0]                grant_cnt, pop_cnt;
  entry_t                    push_a, push_b, head_e, next_e;
  logic [LP_INDEX_WIDTH-1:0] wra_addr_q, wra_addr_d, wrb_addr_q, wrb_addr_d;
  logic [P_MEM_WIDTH-1:0]    wra_data_q, wra_data_d, wrb_data_q, wrb_data_d;
  logic                      wra_valid_q, wra_valid_d, wrb_valid_q, wrb_valid_d;
  logic [LP_PTR_WIDTH-1:0]   offset;
  logic                      lookup_hit;

  // Free space is taken from the registered count; slots popped this cycle are not reused.
  assign free = LP_CNT_WIDTH'(P_FIFO_DEPTH) - count_q;

  wb_rr_grant2 #(
    .P_NUM_SRC    (P_NUM_SRC),
    .P_FREE_WIDTH (LP_CNT_WIDTH)
  ) u_grant (
    .src_valid_i (src_valid_i),
    .rr_i        (rr_q),
    .free_i      (free),
    .grant_a_o   (grant_a),
    .grant_b_o   (grant_b),
    .grant_cnt_o (grant_cnt),
    .rr_next_o   (rr_nxt)
  );

  always_comb begin
    push_a = '0;
    push_b = '0;
    for (int i = 0; i < P_NUM_SRC; i++) begin
      if (grant_a[i]) begin
        push_a.addr = src_addr_i[i*LP_INDEX_WIDTH +: LP_INDEX_WIDTH];
        push_a.data = src_data_i[i*P_MEM_WIDTH +: P_MEM_WIDTH];
      end
      if (grant_b[i]) begin
        push_b.addr = src_addr_i[i*LP_INDEX_WIDTH +: LP_INDEX_WIDTH];
        push_b.data = src_data_i[i*P_MEM_WIDTH +: P_MEM_WIDTH];
      end
    end
  end

  always_comb begin
    head_e      = mem_q[head_q];
    next_e      = mem_q[head_q + LP_PTR_WIDTH'(1)];
    pop_cnt     = 2'd0;
    wra_valid_d = 1'b0;
    wrb_valid_d = 1'b0;
    wra_addr_d  = wra_addr_q;
    wra_data_d  = wra_data_q;
    wrb_addr_d  = wrb_addr_q;
    wrb_data_d  = wrb_data_q;
    if (count_q >= LP_CNT_WIDTH'(1)) begin
      wra_valid_d = 1'b1;
      wra_addr_d  = head_e.addr;
      wra_data_d  = head_e.data;
      pop_cnt     = 2'd1;
      // Equal-address second entry waits a cycle so it lands on port A after the first.
      if ((count_q >= LP_CNT_WIDTH'(2)) && (next_e.addr != head_e.addr)) begin
        wrb_valid_d = 1'b1;
        wrb_addr_d  = next_e.addr;
        wrb_data_d  = next_e.data;
        pop_cnt     = 2'd2;
      end
    end

    mem_d = mem_q;
    if (grant_cnt >= 2'd1) mem_d[tail_q] = push_a;
    if (grant_cnt == 2'd2) mem_d[tail_q + LP_PTR_WIDTH'(1)] = push_b;

    head_d  = head_q + LP_PTR_WIDTH'(pop_cnt);
    tail_d  = tail_q + LP_PTR_WIDTH'(grant_cnt);
    count_d = count_q + LP_CNT_WIDTH'(grant_cnt) - LP_CNT_WIDTH'(pop_cnt);
    rr_d    = rr_nxt;
  end

  always_comb begin
    offset     = '0;
    lookup_hit = (wra_valid_q && (wra_addr_q == lookup_addr_i)) ||
                 (wrb_valid_q && (wrb_addr_q == lookup_addr_i));
    for (int i = 0; i < P_FIFO_DEPTH; i++) begin
      offset = LP_PTR_WIDTH'(i) - head_q;
      if (({1'b0, offset} < count_q) && (mem_q[i].addr == lookup_addr_i)) lookup_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < P_FIFO_DEPTH; i++) mem_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rr_q        <= '0;
      wra_addr_q  <= '0;
      wra_data_q  <= '0;
      wra_valid_q <= 1'b0;
      wrb_addr_q  <= '0;
      wrb_data_q  <= '0;
      wrb_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rr_q        <= rr_d;
      wra_addr_q  <= wra_addr_d;
      wra_data_q  <= wra_data_d;
      wra_valid_q <= wra_valid_d;
      wrb_addr_q  <= wrb_addr_d;
      wrb_data_q  <= wrb_data_d;
      wrb_valid_q <= wrb_valid_d;
    end
  end

  assign src_ready_o  = rst_i ? '0 : (grant_a | grant_b);
  assign wra_addr_o   = wra_addr_q;
  assign wra_data_o   = wra_data_q;
  assign wra_valid_o  = wra_valid_q;
  assign wrb_addr_o   = wrb_addr_q;
  assign wrb_data_o   = wrb_data_q;
  assign wrb_valid_o  = wrb_valid_q;
  assign lookup_hit_o = lookup_hit;
  assign busy_o       = (count_q != '0) || wra_valid_q || wrb_valid_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized + directed bench for wb_write_queue with a queue-level reference model
// and a scoreboard monitor that checks every RAM write against accept order.
module tb_wb_write_queue;

  localparam int N     = 4;
  localparam int IW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  typedef struct {
    logic [IW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    src_valid_i;
  logic [N*IW-1:0] src_addr_i;
  logic [N*DW-1:0] src_data_i;
  logic [N-1:0]    src_ready_o;
  logic [IW-1:0]   wra_addr_o, wrb_addr_o, lookup_addr_i;
  logic [DW-1:0]   wra_data_o, wrb_data_o;
  logic            wra_valid_o, wrb_valid_o, lookup_hit_o, busy_o;

  wb_write_queue dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .src_valid_i   (src_valid_i),
    .src_addr_i    (src_addr_i),
    .src_data_i    (src_data_i),
    .src_ready_o   (src_ready_o),
    .wra_addr_o    (wra_addr_o),
    .wra_data_o    (wra_data_o),
    .wra_valid_o   (wra_valid_o),
    .wrb_addr_o    (wrb_addr_o),
    .wrb_data_o    (wrb_data_o),
    .wrb_valid_o   (wrb_valid_o),
    .lookup_addr_i (lookup_addr_i),
    .lookup_hit_o  (lookup_hit_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending entries, issued-output state, round-robin pointer.
  ent_t          mq[$];
  ent_t          exp_q[$];
  logic          la_v = 1'b0, lb_v = 1'b0;
  logic [IW-1:0] la_addr = '0, lb_addr = '0;
  int            rr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [IW-1:0] a, input logic [DW-1:0] d);
    ent_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: write addr %0h with no pending request expected", name, a);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_addr"}, 64'(a), 64'(e.addr));
      chk({name, "_data"}, 64'(d), 64'(e.data));
    end
  endtask

  // One cycle: check registered outputs, drive inputs, check comb outputs, advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N*IW-1:0] a,
                      input logic [N*DW-1:0] d, input logic [IW-1:0] lk);
    int   free, maxg, ng, last;
    int   gl[$];
    logic [N-1:0] er;
    logic eh, ea, eb;
    ent_t e;
    @(negedge clk_i);
    chk("wra_valid", 64'(wra_valid_o), 64'(la_v));
    chk("wrb_valid", 64'(wrb_valid_o), 64'(lb_v));
    src_valid_i = v; src_addr_i = a; src_data_i = d; lookup_addr_i = lk;
    #1;
    free = DEPTH - mq.size();
    maxg = (free < 2) ? free : 2;
    ng = 0; last = 0; er = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (v[idx] && ng < maxg) begin
        er[idx] = 1'b1;
        gl.push_back(idx);
        ng++;
        last = idx;
      end
    end
    chk("src_ready", 64'(src_ready_o), 64'(er));
    eh = (la_v && la_addr == lk) || (lb_v && lb_addr == lk);
    foreach (mq[j]) if (mq[j].addr == lk) eh = 1'b1;
    chk("lookup_hit", 64'(lookup_hit_o), 64'(eh));
    chk("busy", 64'(busy_o), 64'((mq.size() != 0) || la_v || lb_v));
    ea = (mq.size() >= 1);
    eb = (mq.size() >= 2) && (mq[0].addr != mq[1].addr);
    if (ea) begin la_addr = mq[0].addr; void'(mq.pop_front()); end
    if (eb) begin lb_addr = mq[0].addr; void'(mq.pop_front()); end
    la_v = ea;
    lb_v = eb;
    foreach (gl[j]) begin
      e.addr = a[gl[j]*IW +: IW];
      e.data = d[gl[j]*DW +: DW];
      mq.push_back(e);
      exp_q.push_back(e);
    end
    if (ng > 0) rr = (last + 1) % N;
  endtask

  task automatic idle(input int cycles, input logic [IW-1:0] lk);
    for (int c = 0; c < cycles; c++) step('0, '0, '0, lk);
  endtask

  function automatic logic [IW-1:0] rnd_addr();
    int p;
    p = $urandom_range(0, 8);
    return (p == 8) ? IW'(12'h030) : IW'(p);
  endfunction

  task automatic rnd_step();
    logic [N-1:0]    v;
    logic [N*IW-1:0] a;
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      v[i] = ($urandom_range(0, 99) < 55);
      a[i*IW +: IW] = rnd_addr();
      d[i*DW +: DW] = $urandom;
    end
    step(v, a, d, rnd_addr());
  endtask

  task automatic do_reset(input logic [IW-1:0] lk);
    @(negedge clk_i);
    rst_i = 1'b1;
    src_valid_i = '0;
    lookup_addr_i = lk;
    #1;
    chk("rst_wra_valid", 64'(wra_valid_o), 64'(0));
    chk("rst_wrb_valid", 64'(wrb_valid_o), 64'(0));
    chk("rst_wra_addr", 64'(wra_addr_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_lookup", 64'(lookup_hit_o), 64'(0));
    chk("rst_ready", 64'(src_ready_o), 64'(0));
    mq.delete();
    exp_q.delete();
    la_v = 1'b0;
    lb_v = 1'b0;
    rr = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Scoreboard monitor: every write presented on the RAM ports must be the next accepted request.
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      if (!rst_i) begin
        if (wra_valid_o) pop_cmp("port_a", wra_addr_o, wra_data_o);
        if (wrb_valid_o) pop_cmp("port_b", wrb_addr_o, wrb_data_o);
        if (wra_valid_o && wrb_valid_o)
          chk("ab_addr_distinct", 64'(wra_addr_o != wrb_addr_o), 64'(1));
      end
    end
  end

  initial begin
    logic [N*DW-1:0] fd;
    rst_i = 1'b1; src_valid_i = '0; src_addr_i = '0; src_data_i = '0; lookup_addr_i = '0;
    #1;
    chk("init_wra_valid", 64'(wra_valid_o), 64'(0));
    chk("init_wrb_valid", 64'(wrb_valid_o), 64'(0));
    chk("init_busy", 64'(busy_o), 64'(0));
    chk("init_ready", 64'(src_ready_o), 64'(0));
    chk("init_lookup", 64'(lookup_hit_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    idle(2, '0);
    chk("idle_ready", 64'(src_ready_o), 64'(0));

    // Single request from src1
    step(4'b0010, {11'h0, 11'h0, 11'h010, 11'h0}, {32'h0, 32'h0, 32'hA5A5A5A5, 32'h0}, 11'h0);
    chk("single_ready", 64'(src_ready_o), 64'(4'b0010));
    idle(2, '0);
    chk("single_wra_valid", 64'(wra_valid_o), 64'(1));
    chk("single_wra_addr", 64'(wra_addr_o), 64'(11'h010));
    chk("single_wra_data", 64'(wra_data_o), 64'(32'hA5A5A5A5));
    chk("single_wrb_valid", 64'(wrb_valid_o), 64'(0));
    idle(1, '0);
    chk("single_idle", 64'({wra_valid_o, wrb_valid_o, busy_o}), 64'(0));

    // Bring rr back to 0 via src3, then all four sources
    step(4'b1000, {11'h7ff, 33'h0}, {32'h12345678, 96'h0}, '0);
    idle(3, '0);
    step(4'b1111, {11'h103, 11'h102, 11'h101, 11'h100}, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, '0);
    chk("all4_first_grant", 64'(src_ready_o), 64'(4'b0011));
    step(4'b1111, {11'h103, 11'h102, 11'h101, 11'h100}, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, '0);
    chk("all4_second_grant", 64'(src_ready_o), 64'(4'b1100));
    idle(1, '0);
    chk("pair1_a", 64'(wra_addr_o), 64'(11'h100));
    chk("pair1_b", 64'({wrb_valid_o, wrb_addr_o}), 64'({1'b1, 11'h101}));
    idle(1, '0);
    chk("pair2_a", 64'(wra_addr_o), 64'(11'h102));
    chk("pair2_b", 64'({wrb_valid_o, wrb_addr_o}), 64'({1'b1, 11'h103}));
    idle(2, '0);

    // Same-address head pair
    step(4'b0011, {22'h0, 11'h020, 11'h020}, {64'h0, 32'd2, 32'd1}, '0);
    idle(2, '0);
    chk("same_first_data", 64'(wra_data_o), 64'(1));
    chk("same_first_b_idle", 64'(wrb_valid_o), 64'(0));
    idle(1, '0);
    chk("same_second_data", 64'({wra_valid_o, wra_data_o}), 64'({1'b1, 32'd2}));
    chk("same_second_b_idle", 64'(wrb_valid_o), 64'(0));
    idle(2, '0);

    // Fill: one address everywhere halves drain rate, so the queue backs up to the limit
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < N; i++) fd[i*DW +: DW] = $urandom;
      step(4'b1111, {4{11'h005}}, fd, 11'h005);
      if (c == 10) chk("fill_single_grant", 64'($countones(src_ready_o)), 64'(1));
    end
    idle(10, 11'h005);

    // Lookup lifetime of a single queued write
    step(4'b0001, {33'h0, 11'h030}, {96'h0, 32'hC0FFEE}, 11'h030);
    chk("lookup_excl_handshake", 64'(lookup_hit_o), 64'(0));
    idle(1, 11'h030);
    chk("lookup_queued", 64'(lookup_hit_o), 64'(1));
    idle(1, 11'h030);
    chk("lookup_issuing", 64'({wra_valid_o, lookup_hit_o}), 64'(2'b11));
    idle(1, 11'h030);
    chk("lookup_retired", 64'(lookup_hit_o), 64'(0));

    // Reset mid-stream with 0x030 pending
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) fd[i*DW +: DW] = $urandom;
      step(4'b1111, {4{11'h030}}, fd, 11'h030);
    end
    do_reset(11'h030);
    idle(3, 11'h030);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rnd_step();
      if (c == 200) do_reset(rnd_addr());
    end
    idle(12, '0);
    chk("drain_scoreboard_empty", 64'(exp_q.size()), 64'(0));
    chk("drain_busy", 64'(busy_o), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
